// File: rtl/tmr_fault_monitor_pkg.sv
// Shared widths, health-state encoding and helpers for the TMR fault monitor.
// Optional timestamp capture is enabled with the TMR_MON_TIMESTAMP_EN macro.
package tmr_mon_pkg;

    localparam int unsigned NSIG        = 13;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned FAIL_THRESH = 4;
    localparam int unsigned TS_W        = 16;
    localparam int unsigned SIG_W       = $clog2(NSIG);

    typedef enum logic [1:0] {
        ST_TMR     = 2'b00,
        ST_SIMPLEX = 2'b01,
        ST_FATAL   = 2'b10
    } tmr_state_t;

    function automatic logic [1:0] count_ones3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Lowest set bit index; scanning downward lets the lowest hit win.
    function automatic logic [SIG_W-1:0] lowest_idx(input logic [NSIG-1:0] v);
        logic [SIG_W-1:0] idx;
        idx = '0;
        for (int i = int'(NSIG) - 1; i >= 0; i--) begin
            if (v[i]) idx = SIG_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tmr_fault_monitor_if.sv
// Status/control bundle between the TMR voter bank, the monitor and its host.
interface tmr_fault_monitor_if;
    import tmr_mon_pkg::*;

    logic              a_dis;
    logic              b_dis;
    logic              c_dis;
    logic [NSIG-1:0]   err_vec;
    logic              clr;
    logic              irq_ack;
    tmr_state_t        state;
    logic [2:0]        copy_failed;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_c;
    logic              first_valid;
    logic [SIG_W-1:0]  first_sig;
    logic [TS_W-1:0]   first_time;
    logic              irq;

    modport master (
        output a_dis, b_dis, c_dis, err_vec, clr, irq_ack,
        input  state, copy_failed, cnt_a, cnt_b, cnt_c,
               first_valid, first_sig, first_time, irq
    );

    modport slave (
        input  a_dis, b_dis, c_dis, err_vec, clr, irq_ack,
        output state, copy_failed, cnt_a, cnt_b, cnt_c,
               first_valid, first_sig, first_time, irq
    );
endinterface

// File: rtl/tmr_fault_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its next value.
module tmr_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_cnt_nxt_c
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;

    always_comb begin
        o_cnt_nxt_c = r_cnt;
        if (i_clr)                         o_cnt_nxt_c = '0;
        else if (i_inc && r_cnt != CNT_MAX) o_cnt_nxt_c = r_cnt + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else      r_cnt <= o_cnt_nxt_c;
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR health monitor: per-copy disagreement counts, TMR/SIMPLEX/FATAL FSM,
// first-error capture and level irq. TMR_MON_TIMESTAMP_EN adds a capture timestamp.
module tmr_fault_monitor
    import tmr_mon_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    tmr_fault_monitor_if.slave  bus
);
    logic [CNT_W-1:0] w_cnt_a, w_cnt_b, w_cnt_c;
    logic [CNT_W-1:0] w_nxt_a, w_nxt_b, w_nxt_c;
    logic [2:0]       w_thr;
    logic [1:0]       w_n_failed;
    logic             w_err_any;
    logic [TS_W-1:0]  w_ts;

    logic [2:0]       r_copy_failed;
    logic [NSIG-1:0]  r_err_vec;
    tmr_state_t       r_state;
    logic             r_irq;
    logic             r_first_valid;
    logic [SIG_W-1:0] r_first_sig;
    logic [TS_W-1:0]  r_first_time;

    tmr_sat_counter #(.W(CNT_W)) u_cnt_a (.clk(clk), .rst(rst), .i_clr(bus.clr), .i_inc(bus.a_dis),
                                          .o_cnt(w_cnt_a), .o_cnt_nxt_c(w_nxt_a));
    tmr_sat_counter #(.W(CNT_W)) u_cnt_b (.clk(clk), .rst(rst), .i_clr(bus.clr), .i_inc(bus.b_dis),
                                          .o_cnt(w_cnt_b), .o_cnt_nxt_c(w_nxt_b));
    tmr_sat_counter #(.W(CNT_W)) u_cnt_c (.clk(clk), .rst(rst), .i_clr(bus.clr), .i_inc(bus.c_dis),
                                          .o_cnt(w_cnt_c), .o_cnt_nxt_c(w_nxt_c));

    // Retire on the same edge the counter reaches the threshold.
    assign w_thr = {w_nxt_c >= CNT_W'(FAIL_THRESH),
                    w_nxt_b >= CNT_W'(FAIL_THRESH),
                    w_nxt_a >= CNT_W'(FAIL_THRESH)};

    assign w_n_failed = count_ones3(r_copy_failed);
    assign w_err_any  = |r_err_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_copy_failed <= '0;
            r_err_vec     <= '0;
        end else if (bus.clr) begin
            r_copy_failed <= '0;
            r_err_vec     <= '0;
        end else begin
            r_copy_failed <= r_copy_failed | w_thr;
            r_err_vec     <= bus.err_vec;
        end
    end

    // Health FSM; a transition into SIMPLEX/FATAL overrides a same-cycle ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_TMR;
            r_irq   <= 1'b0;
        end else if (bus.clr) begin
            r_state <= ST_TMR;
            r_irq   <= 1'b0;
        end else begin
            if (bus.irq_ack) r_irq <= 1'b0;
            case (r_state)
                ST_TMR: begin
                    if (w_n_failed >= 2'd2 || w_err_any) begin
                        r_state <= ST_FATAL;
                        r_irq   <= 1'b1;
                    end else if (w_n_failed == 2'd1) begin
                        r_state <= ST_SIMPLEX;
                        r_irq   <= 1'b1;
                    end
                end
                ST_SIMPLEX: begin
                    if (w_n_failed >= 2'd2 || w_err_any) begin
                        r_state <= ST_FATAL;
                        r_irq   <= 1'b1;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

`ifdef TMR_MON_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running; deliberately untouched by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_ts <= '0;
        else      r_ts <= r_ts + TS_W'(1);
    end
    assign w_ts = r_ts;
`else
    assign w_ts = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first_valid <= 1'b0;
            r_first_sig   <= '0;
            r_first_time  <= '0;
        end else if (bus.clr) begin
            r_first_valid <= 1'b0;
            r_first_sig   <= '0;
            r_first_time  <= '0;
        end else if (!r_first_valid && (|bus.err_vec)) begin
            r_first_valid <= 1'b1;
            r_first_sig   <= lowest_idx(bus.err_vec);
            r_first_time  <= w_ts;
        end
    end

    assign bus.state       = r_state;
    assign bus.irq         = r_irq;
    assign bus.copy_failed = r_copy_failed;
    assign bus.cnt_a       = w_cnt_a;
    assign bus.cnt_b       = w_cnt_b;
    assign bus.cnt_c       = w_cnt_c;
    assign bus.first_valid = r_first_valid;
    assign bus.first_sig   = r_first_sig;
    assign bus.first_time  = r_first_time;
endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor; expectations are queued then popped against outputs.
module tb_tmr_fault_monitor;
    import tmr_mon_pkg::*;

    logic clk;
    logic rst;

    tmr_fault_monitor_if u_if ();

    tmr_fault_monitor u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h required an entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] st();
        return 32'(u_if.state);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        u_if.a_dis    = 1'b0;
        u_if.b_dis    = 1'b0;
        u_if.c_dis    = 1'b0;
        u_if.err_vec  = '0;
        u_if.clr      = 1'b0;
        u_if.irq_ack  = 1'b0;

        // Reset and idle.
        tick(); tick();
        push("rst_state", 32'd0);    pop_check(st());
        push("rst_irq", 32'd0);      pop_check(32'(u_if.irq));
        rst = 1'b1;
        repeat (100) tick();
        push("idle_state", 32'd0);   pop_check(st());
        push("idle_irq", 32'd0);     pop_check(32'(u_if.irq));
        push("idle_cnt_a", 32'd0);   pop_check(32'(u_if.cnt_a));
        push("idle_fvalid", 32'd0);  pop_check(32'(u_if.first_valid));
        push("idle_cf", 32'd0);      pop_check(32'(u_if.copy_failed));

        // Four a_dis pulses retire copy A, then SIMPLEX one edge later.
        u_if.a_dis = 1'b1;
        repeat (3) tick();
        push("a3_cnt", 32'd3);       pop_check(32'(u_if.cnt_a));
        push("a3_cf", 32'd0);        pop_check(32'(u_if.copy_failed));
        tick();
        u_if.a_dis = 1'b0;
        push("a4_cnt", 32'd4);       pop_check(32'(u_if.cnt_a));
        push("a4_cf", 32'b001);      pop_check(32'(u_if.copy_failed));
        push("a4_state_lag", 32'd0); pop_check(st());
        tick();
        push("simplex_state", 32'd1); pop_check(st());
        push("simplex_irq", 32'd1);   pop_check(32'(u_if.irq));
        u_if.irq_ack = 1'b1;
        tick();
        u_if.irq_ack = 1'b0;
        push("ack_irq", 32'd0);      pop_check(32'(u_if.irq));
        tick();
        push("ack_state", 32'd1);    pop_check(st());

        // Error vector from SIMPLEX: capture lowest index, go FATAL after two edges.
        u_if.err_vec = 13'h0048;
        tick();
        u_if.err_vec = '0;
        push("cap_valid", 32'd1);    pop_check(32'(u_if.first_valid));
        push("cap_sig", 32'd3);      pop_check(32'(u_if.first_sig));
        push("cap_state_lag", 32'd1); pop_check(st());
        tick();
        push("fatal_state", 32'd2);  pop_check(st());
        push("fatal_irq", 32'd1);    pop_check(32'(u_if.irq));
        u_if.err_vec = 13'h0001;
        tick();
        u_if.err_vec = '0;
        tick();
        push("cap_keep", 32'd3);     pop_check(32'(u_if.first_sig));
        push("fatal_absorb", 32'd2); pop_check(st());
        u_if.irq_ack = 1'b1;
        tick();
        u_if.irq_ack = 1'b0;
        push("fatal_ack", 32'd0);    pop_check(32'(u_if.irq));

        // Double failure: TMR straight to FATAL.
        u_if.clr = 1'b1;
        tick();
        u_if.clr = 1'b0;
        push("clr_state", 32'd0);    pop_check(st());
        push("clr_fvalid", 32'd0);   pop_check(32'(u_if.first_valid));
        u_if.a_dis = 1'b1;
        u_if.b_dis = 1'b1;
        repeat (4) tick();
        u_if.a_dis = 1'b0;
        u_if.b_dis = 1'b0;
        push("ab_cf", 32'b011);      pop_check(32'(u_if.copy_failed));
        push("ab_cnt_b", 32'd4);     pop_check(32'(u_if.cnt_b));
        push("ab_state_lag", 32'd0); pop_check(st());
        tick();
        push("ab_state", 32'd2);     pop_check(st());
        push("ab_irq", 32'd1);       pop_check(32'(u_if.irq));

        // Saturation, then clr beats a same-cycle a_dis.
        u_if.clr = 1'b1;
        tick();
        u_if.clr = 1'b0;
        u_if.c_dis = 1'b1;
        repeat (300) tick();
        push("sat_cnt_c", 32'd255);  pop_check(32'(u_if.cnt_c));
        push("sat_cf", 32'b100);     pop_check(32'(u_if.copy_failed));
        push("sat_state", 32'd1);    pop_check(st());
        u_if.c_dis = 1'b0;
        u_if.a_dis = 1'b1;
        u_if.clr   = 1'b1;
        tick();
        u_if.a_dis = 1'b0;
        u_if.clr   = 1'b0;
        push("clr2_cnt_a", 32'd0);   pop_check(32'(u_if.cnt_a));
        push("clr2_cnt_c", 32'd0);   pop_check(32'(u_if.cnt_c));
        push("clr2_state", 32'd0);   pop_check(st());
        push("clr2_irq", 32'd0);     pop_check(32'(u_if.irq));
        push("clr2_cf", 32'd0);      pop_check(32'(u_if.copy_failed));

        // Set irq while irq_ack is held: set must win.
        u_if.c_dis = 1'b1;
        repeat (4) tick();
        u_if.c_dis   = 1'b0;
        u_if.irq_ack = 1'b1;
        tick();
        u_if.irq_ack = 1'b0;
        push("setwin_state", 32'd1); pop_check(st());
        push("setwin_irq", 32'd1);   pop_check(32'(u_if.irq));

        // Drive to FATAL, then asynchronous reset mid-cycle.
        u_if.err_vec = 13'h0010;
        tick();
        u_if.err_vec = '0;
        tick();
        push("pre_rst_state", 32'd2); pop_check(st());
        #2;
        rst = 1'b0;
        #1;
        push("arst_state", 32'd0);   pop_check(st());
        push("arst_irq", 32'd0);     pop_check(32'(u_if.irq));
        push("arst_cnt_c", 32'd0);   pop_check(32'(u_if.cnt_c));
        push("arst_fvalid", 32'd0);  pop_check(32'(u_if.first_valid));
        tick();
        rst = 1'b1;
        repeat (50) tick();
        u_if.err_vec = 13'h0100;
        tick();
        u_if.err_vec = '0;
        push("ts_sig", 32'd8);       pop_check(32'(u_if.first_sig));
`ifdef TMR_MON_TIMESTAMP_EN
        push("ts_time", 32'd50);     pop_check(32'(u_if.first_time));
`else
        push("ts_time", 32'd0);      pop_check(32'(u_if.first_time));
`endif
        tick();

        if (exp_q.size() != 0) begin
            n_total++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
